// File: rtl/decoder_2_4_pkg.sv
// Shared widths and reset value for the 2-to-4 one-hot decoder.
package decoder_2_4_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned OUT_W = 4;

  localparam logic [OUT_W-1:0] BCODE_RST = 4'b0000;

endpackage : decoder_2_4_pkg

// File: rtl/decoder_2_4_core.sv
// Combinational 2-to-4 one-hot decode with active-high enable.
module decoder_2_4_core
  import decoder_2_4_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] a,
  output logic [OUT_W-1:0] bcode
);

  always_comb begin
    bcode = BCODE_RST;
    if (en) begin
      case (a)
        2'd0:    bcode = 4'b0001;
        2'd1:    bcode = 4'b0010;
        2'd2:    bcode = 4'b0100;
        2'd3:    bcode = 4'b1000;
        default: bcode = BCODE_RST;
      endcase
    end
  end

endmodule : decoder_2_4_core

// File: rtl/decoder_2_4.sv
// 2-to-4 decoder top: core decode plus optional one-cycle output register.
module decoder_2_4
  import decoder_2_4_pkg::*;
#(
  parameter int unsigned OUT_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SEL_W-1:0] a,
  output logic [OUT_W-1:0] bcode
);

  logic [OUT_W-1:0] bcode_d;

  decoder_2_4_core u_core (
    .en    (en),
    .a     (a),
    .bcode (bcode_d)
  );

  if (OUT_REG != 0) begin : g_reg
    logic [OUT_W-1:0] bcode_q;

    always_ff @(posedge clk) begin
      if (reset) bcode_q <= BCODE_RST;
      else       bcode_q <= bcode_d;
    end

    assign bcode = bcode_q;
  end else begin : g_comb
    // clk and reset deliberately have no path to the output in this variant.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign bcode          = bcode_d;
  end

endmodule : decoder_2_4

// File: tb/tb_decoder_2_4.sv
// Directed self-checking bench for decoder_2_4 (registered and combinational variants).
module tb_decoder_2_4;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] a;
  logic [3:0] bcode_r;
  logic [3:0] bcode_c;

  int unsigned n_vec;
  int unsigned n_err;

  decoder_2_4 #(.OUT_REG(1)) dut_r (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .a     (a),
    .bcode (bcode_r)
  );

  decoder_2_4 #(.OUT_REG(0)) dut_c (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .a     (a),
    .bcode (bcode_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] step_exp [4];
  logic [3:0] comb_exp [8];

  initial begin
    step_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    comb_exp = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    en    = 1'b0;
    a     = 2'b00;

    // Reset held two cycles, then released with en=0.
    tick();
    check("rst_cyc1", bcode_r, 4'b0000);
    tick();
    check("rst_cyc2", bcode_r, 4'b0000);
    reset = 1'b0;
    tick();
    check("rst_release_en0", bcode_r, 4'b0000);

    // Enabled sweep, each code held 20 cycles; output lags a by one edge.
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      #1;
      check("sweep_latency", bcode_r, (i == 0) ? 4'b0000 : step_exp[i-1]);
      for (int c = 0; c < 20; c++) begin
        tick();
        check("sweep_hold", bcode_r, step_exp[i]);
      end
    end

    // Disabled: a changes must not reach the output.
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      tick();
      check("disabled", bcode_r, 4'b0000);
    end

    // One-cycle reset pulse mid-operation.
    en = 1'b1;
    a  = 2'b10;
    tick();
    check("pulse_before", bcode_r, 4'b0100);
    reset = 1'b1;
    tick();
    check("pulse_reset", bcode_r, 4'b0000);
    reset = 1'b0;
    tick();
    check("pulse_after", bcode_r, 4'b0100);

    // en rises on the same edge a moves 01->11: no intermediate code.
    en = 1'b0;
    a  = 2'b01;
    tick();
    check("simul_pre", bcode_r, 4'b0000);
    en = 1'b1;
    a  = 2'b11;
    @(negedge clk);
    check("simul_between", bcode_r, 4'b0000);
    tick();
    check("simul_post", bcode_r, 4'b1000);
    @(negedge clk);
    check("simul_stable", bcode_r, 4'b1000);

    // Combinational variant: zero latency, immune to clk and reset.
    for (int i = 0; i < 8; i++) begin
      {en, a} = 3'(i);
      reset   = 1'b0;
      #1;
      check("comb_sweep", bcode_c, comb_exp[i]);
      reset = 1'b1;
      #1;
      check("comb_reset", bcode_c, comb_exp[i]);
      tick();
      check("comb_clk", bcode_c, comb_exp[i]);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_decoder_2_4
